fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Front-end controller ahead of the decode stage.
- Owns the program counter and issues byte fetches to instruction memory over a req/ack handshake.
- Buffers returned bytes in a small prefetch queue and presents one byte per cycle to decode as its opcode input.
- Honours decode's stall_en back-pressure and handles taken-branch redirects, halt, and in-flight fetch cancellation.

Parameters:
- ADDR_W, 8, program counter and memory address width.
- BUF_DEPTH, 2, prefetch queue entries (power of two, at least 2).
- RESET_PC, 0, fetch address loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- sync_rst  input  1  synchronous active-high reset.
- mem_req  output  1  fetch request; held until accepted.
- mem_addr  output  ADDR_W  fetch address; stable while mem_req is high.
- mem_ack  input  1  request accepted; mem_rdata is valid in this same cycle.
- mem_rdata  input  8  fetched byte.
- opcode_out  output  8  byte at queue head, fed to decode opcode.
- opcode_valid  output  1  queue non-empty.
- opcode_pc  output  ADDR_W  address of the head byte.
- stall_en  input  1  decode stall; head is not consumed this cycle.
- redirect_en  input  1  taken branch/jump; flush and refetch.
- redirect_pc  input  ADDR_W  new fetch address.
- halt  input  1  stop issuing new fetches (level).
- busy  output  1  fetch outstanding or FLUSH state.

Behaviour:
- Reset, sync_rst high at a clock edge:
  - fetch_pc <= RESET_PC; queue count <= 0; state <= IDLE.
  - Combinational outputs then read: mem_req=0, opcode_valid=0, opcode_out=8'h00, opcode_pc=0, busy=0.
  - Reset overrides every other input in that cycle, including mid-request. A pending request is abandoned; memory must tolerate a dropped request on reset.
- States:
  - IDLE: one cycle after reset, no request; then goes to RUN.
  - RUN: normal fetching.
  - FLUSH: an old request is still outstanding after a redirect.
- Issue rule (RUN only): mem_req=1 when count + outstanding < BUF_DEPTH and halt=0. mem_addr=fetch_pc.
  - Only one request is outstanding at a time.
  - Once mem_req is raised, it and mem_addr stay constant until the mem_ack cycle, even if halt rises.
- Transfer: mem_req and mem_ack both high.
  - Push {fetch_pc, mem_rdata} into the queue.
  - fetch_pc <= fetch_pc+1, wrapping modulo 2^ADDR_W (0xFF -> 0x00).
  - mem_req may stay high back-to-back for the next address. With zero-wait memory this gives 1 byte/cycle.
- Consume: opcode_valid=1 and stall_en=0 pops the head.
  - Push and pop in the same cycle is allowed when full or empty. When empty the pushed byte appears next cycle; there is no combinational bypass.
- Latency: mem_ack at cycle N -> opcode_valid at N+1. Reset released at N -> first mem_req at N+2.
- When the queue is empty, opcode_out=8'h00 (NOP encoding) and opcode_valid=0.
- Redirect has highest priority after reset:
  - Queue cleared; any same-cycle pop and push are discarded.
  - fetch_pc <= redirect_pc.
  - If a request is outstanding without an ack this cycle, go to FLUSH. Otherwise stay in RUN; a new request may issue next cycle.
- FLUSH:
  - mem_req/mem_addr held at the old request.
  - On mem_ack the data is dropped, fetch_pc is unchanged, and the state returns to RUN.
  - A redirect while in FLUSH updates fetch_pc only and stays in FLUSH.
  - The queue stays empty in FLUSH.
- halt: the queue continues draining to decode. Fetching resumes the cycle after halt falls.
- busy = (mem_req high) or (state==FLUSH).

Decomposition:
- fetch_pkg:
  - state enum {IDLE, RUN, FLUSH}.
  - NOP_OPC=8'h00.
  - Entry struct {pc[ADDR_W], byte[8]}.
- Sub-module fetch_queue:
  - Parameterised synchronous FIFO with push, pop and clear.
  - Outputs count, head and full; clear has priority.

Test Plan:
- Zero-wait memory returns mem_rdata=addr^8'hA5; stall_en=0 -> bytes A5,A4,A7,... at addr 0,1,2, one per cycle. First opcode_valid 3 cycles after reset release.
- Hold stall_en=1 for 5 cycles after the queue fills -> exactly BUF_DEPTH bytes queued, mem_req low. Release stall -> no byte lost or duplicated, order preserved.
- mem_ack delayed 3 cycles -> mem_addr stable through wait, opcode_valid low until the byte arrives.
- Request outstanding to addr 0x05; redirect_pc=0x40 -> FLUSH, ack data for 0x05 dropped, next request addr 0x40, first opcode_pc=0x40.
- RESET_PC=0xFE -> fetch addresses 0xFE, 0xFF, 0x00, 0x01 with wrap.
- sync_rst asserted during a wait state and during FLUSH -> next cycle all outputs at reset values. Assert halt with queue full -> queue drains, no new mem_req until halt drops.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the sequencer state encoding, the NOP opcode and the queue entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam logic [7:0] NOP_OPC = 8'h00;

    // Entry layout for the default 8-bit address width; the sequencer
    // declares an equivalent layout sized to its own ADDR_W.
    localparam int ENTRY_PC_W = 8;

    typedef struct packed {
        logic [ENTRY_PC_W-1:0] pc;
        logic [7:0]            opc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO for prefetched bytes: push, pop and clear.
// Clear wins over push/pop; push into a full queue is accepted only with a same-cycle pop.
module fetch_queue #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     sync_rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_o  = (cnt_q == CNT_W'(DEPTH));
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && (!full_o || do_pop);
        head_o  = mem_q[rd_q];
        count_o = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (sync_rst_i || clear_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, fetches bytes over req/ack and feeds decode.
// Handshake: a transfer happens when mem_req and mem_ack are both high; mem_req/mem_addr hold until then.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              sync_rst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        opcode_out,
    output logic              opcode_valid,
    output logic [ADDR_W-1:0] opcode_pc,
    input  logic              stall_en,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              busy
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [7:0]        opc;
    } entry_t;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_pend_q, req_pend_d;

    logic              issue_new;
    logic              xfer;
    logic              q_push;
    logic              q_pop;
    logic              q_full;
    logic [CNT_W-1:0]  q_count;
    entry_t            q_head;
    entry_t            q_din;

    always_comb begin
        // A raised request is latched in req_pend_q so halt or a redirect cannot pull it back.
        issue_new    = (state_q == RUN) && !req_pend_q && !halt && !q_full;
        mem_req      = req_pend_q || issue_new;
        mem_addr     = req_pend_q ? req_addr_q : fetch_pc_q;
        xfer         = mem_req && mem_ack;

        opcode_valid = (q_count != '0);
        opcode_out   = opcode_valid ? q_head.opc : NOP_OPC;
        opcode_pc    = opcode_valid ? q_head.pc  : '0;
        busy         = mem_req || (state_q == FLUSH);

        q_push       = (state_q == RUN) && xfer && !redirect_en;
        q_pop        = opcode_valid && !stall_en;
        q_din.pc     = mem_addr;
        q_din.opc    = mem_rdata;
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pend_d = mem_req && !mem_ack;
        req_addr_d = mem_addr;

        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_en && mem_req && !mem_ack) begin
                    state_d = FLUSH;
                end else if (xfer) begin
                    fetch_pc_d = fetch_pc_q + ADDR_W'(1);
                end
            end
            FLUSH: begin
                // The stale byte is dropped; fetch_pc already points at the redirect target.
                if (mem_ack) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_en) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pend_q <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pend_q <= req_pend_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_queue #(
        .W     ($bits(entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk        (clk),
        .sync_rst_i (sync_rst),
        .clear_i    (redirect_en),
        .push_i     (q_push),
        .pop_i      (q_pop),
        .din_i      (q_din),
        .head_o     (q_head),
        .count_o    (q_count),
        .full_o     (q_full)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed phases then random traffic against a queue-based reference.
// A second instance with RESET_PC=0xFE and zero-wait memory exercises address wrap.
module tb_fetch_sequencer;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       sync_rst;
    logic       mem_req, mem_ack;
    logic [7:0] mem_addr, mem_rdata;
    logic [7:0] opcode_out, opcode_pc;
    logic       opcode_valid;
    logic       stall_en, redirect_en, halt, busy;
    logic [7:0] redirect_pc;

    logic       fe_req, fe_valid, fe_busy;
    logic [7:0] fe_addr, fe_opc, fe_opc_pc, fe_rdata;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(8), .BUF_DEPTH(DEPTH), .RESET_PC(8'h00)) u_dut (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .opcode_out   (opcode_out),
        .opcode_valid (opcode_valid),
        .opcode_pc    (opcode_pc),
        .stall_en     (stall_en),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .halt         (halt),
        .busy         (busy)
    );

    assign fe_rdata = fe_addr ^ 8'hA5;

    fetch_sequencer #(.ADDR_W(8), .BUF_DEPTH(DEPTH), .RESET_PC(8'hFE)) u_dut_fe (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .mem_req      (fe_req),
        .mem_addr     (fe_addr),
        .mem_ack      (fe_req),
        .mem_rdata    (fe_rdata),
        .opcode_out   (fe_opc),
        .opcode_valid (fe_valid),
        .opcode_pc    (fe_opc_pc),
        .stall_en     (1'b0),
        .redirect_en  (1'b0),
        .redirect_pc  (8'h00),
        .halt         (1'b0),
        .busy         (fe_busy)
    );

    // Reference model: queued {pc, byte} entries plus the fetch bookkeeping.
    logic [15:0] exp_q[$];
    logic [7:0]  m_pc, m_pend_addr;
    bit          m_idle, m_pend, m_flush;
    logic [7:0]  fe_exp_pc;
    bit          fe_idle;
    int          mem_cnt, mem_target, lat_lo, lat_hi;
    int          checks, errors;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_req(input bit hlt);
        if (m_idle) return 1'b0;
        if (m_pend) return 1'b1;
        return !m_flush && !hlt && (exp_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_pc      = 8'h00;
        m_idle    = 1'b1;
        m_pend    = 1'b0;
        m_flush   = 1'b0;
        mem_cnt   = 0;
        fe_idle   = 1'b1;
        fe_exp_pc = 8'hFE;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_mem_req"}, mem_req, 8'h00);
        chk({tag, "_valid"}, opcode_valid, 8'h00);
        chk({tag, "_opcode"}, opcode_out, 8'h00);
        chk({tag, "_pc"}, opcode_pc, 8'h00);
        chk({tag, "_busy"}, busy, 8'h00);
    endtask

    // One clock: drive at negedge, check after settling, update model at posedge.
    task automatic step(input bit rst, input bit stall, input bit hlt, input bit redir,
                        input logic [7:0] rpc);
        bit         r, ack, has;
        logic [7:0] a;
        r   = model_req(hlt);
        a   = m_pend ? m_pend_addr : m_pc;
        ack = r && !rst && (mem_cnt >= mem_target);
        has = exp_q.size() > 0;
        sync_rst    = rst;
        stall_en    = stall;
        halt        = hlt;
        redirect_en = redir;
        redirect_pc = rpc;
        mem_ack     = ack;
        mem_rdata   = mem_addr ^ 8'hA5;
        #1;
        chk("opcode_valid", opcode_valid, has);
        chk("opcode_out", opcode_out, has ? exp_q[0][7:0] : 8'h00);
        chk("opcode_pc", opcode_pc, has ? exp_q[0][15:8] : 8'h00);
        chk("mem_req", mem_req, r);
        if (r) chk("mem_addr", mem_addr, a);
        chk("busy", busy, r || m_flush);
        chk("fe_mem_req", fe_req, !fe_idle);
        if (!fe_idle) chk("fe_mem_addr", fe_addr, fe_exp_pc);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_idle) begin
                m_idle = 1'b0;
                if (redir) m_pc = rpc;
            end else if (redir) begin
                exp_q.delete();
                if (m_flush) begin
                    if (ack) begin
                        m_flush = 1'b0;
                        m_pend  = 1'b0;
                    end
                end else begin
                    m_pend      = r && !ack;
                    m_flush     = m_pend;
                    m_pend_addr = a;
                end
                m_pc = rpc;
            end else if (m_flush) begin
                if (ack) begin
                    m_flush = 1'b0;
                    m_pend  = 1'b0;
                end
            end else begin
                if (has && !stall) void'(exp_q.pop_front());
                if (r && ack) begin
                    exp_q.push_back({a, a ^ 8'hA5});
                    m_pc = a + 8'h01;
                end
                m_pend      = r && !ack;
                m_pend_addr = a;
            end
            if (!r) mem_cnt = 0;
            else if (ack) begin
                mem_cnt    = 0;
                mem_target = $urandom_range(lat_hi, lat_lo);
            end else mem_cnt++;
            if (fe_idle) fe_idle = 1'b0;
            else fe_exp_pc = fe_exp_pc + 8'h01;
        end
        @(negedge clk);
    endtask

    task automatic set_latency(input int lo, input int hi);
        lat_lo     = lo;
        lat_hi     = hi;
        mem_target = $urandom_range(hi, lo);
    endtask

    initial begin
        bit found;
        checks = 0;
        errors = 0;
        sync_rst = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
        stall_en = 1'b0; redirect_en = 1'b0; redirect_pc = 8'h00; halt = 1'b0;
        set_latency(0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_checks("por");

        // Zero-wait streaming: first byte visible on the third cycle after reset.
        step(0, 0, 0, 0, 8'h00);
        chk("first_valid_early", opcode_valid, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        chk("first_valid", opcode_valid, 8'h01);
        chk("first_opcode", opcode_out, 8'hA5);
        repeat (12) step(0, 0, 0, 0, 8'h00);

        // Back-pressure: fill the queue, hold 5 more cycles, release.
        repeat (7) step(0, 1, 0, 0, 8'h00);
        chk("stall_no_req", mem_req, 8'h00);
        repeat (10) step(0, 0, 0, 0, 8'h00);

        // Slow memory.
        set_latency(3, 3);
        repeat (20) step(0, 0, 0, 0, 8'h00);

        // Redirect while the request for 0x05 is waiting.
        step(1, 0, 0, 0, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (m_pend && !m_flush && m_pend_addr == 8'h05) found = 1'b1;
            else step(0, 0, 0, 0, 8'h00);
        end
        chk("redir_setup_reached", found, 8'h01);
        step(0, 0, 0, 1, 8'h40);
        chk("flush_busy", busy, 8'h01);
        chk("flush_addr_held", mem_addr, 8'h05);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(0, 0, 0, 0, 8'h00);
            if (exp_q.size() > 0) found = 1'b1;
        end
        chk("redir_data_seen", found, 8'h01);
        chk("redir_first_pc", opcode_pc, 8'h40);

        // Reset during a memory wait state.
        step(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10 && !(m_pend && mem_cnt > 0); i++) step(0, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        reset_checks("rst_wait");

        // Reset during FLUSH.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_pend && !m_flush) found = 1'b1;
            else step(0, 0, 0, 0, 8'h00);
        end
        step(0, 0, 0, 1, 8'h80);
        chk("rst_flush_entered", busy, 8'h01);
        step(1, 0, 0, 0, 8'h00);
        reset_checks("rst_flush");

        // Halt with a full queue: drain without new fetches, then resume.
        set_latency(0, 0);
        repeat (5) step(0, 1, 0, 0, 8'h00);
        repeat (6) step(0, 0, 1, 0, 8'h00);
        chk("halt_drained", opcode_valid, 8'h00);
        chk("halt_no_req", mem_req, 8'h00);
        repeat (6) step(0, 0, 0, 0, 8'h00);

        // Random traffic.
        set_latency(0, 3);
        for (int i = 0; i < 900; i++) begin
            step($urandom_range(99, 0) < 1,
                 $urandom_range(99, 0) < 30,
                 $urandom_range(99, 0) < 15,
                 $urandom_range(99, 0) < 6,
                 8'($urandom_range(255, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
